// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target engine, MSB first, 8-bit frames.
// The host's SCK, MOSI and CS_n are oversampled in the clk domain. A single-byte
// TX holding register and a single-byte RX holding register face the register side.
// Sticky overrun/underrun flags report lost data.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   spi_sck/mosi/cs_n        host pins (asynchronous to clk)
//   spi_miso, spi_miso_oe    target data out and its output enable
//   txdata, txwrite, txempty TX holding register write port and status
//   rxdata, rxavail, rxread  RX holding register and its read handshake
//   err_clear, overrun, underrun  sticky error flags and their clear
//   selected, busy           link status
module spi_target #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [7:0]  UNDERRUN_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sck,
    input  logic       spi_mosi,
    input  logic       spi_cs_n,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic [7:0] txdata,
    input  logic       txwrite,
    output logic       txempty,
    output logic [7:0] rxdata,
    output logic       rxavail,
    input  logic       rxread,
    input  logic       err_clear,
    output logic       overrun,
    output logic       underrun,
    output logic       selected,
    output logic       busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BYTE_W);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // Pin synchronizers; CS_n resets to the deselected level.
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_n_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_n_sync <= '1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_n_sync <= {cs_n_sync[SYNC_STAGES-2:0], spi_cs_n};
        end
    end

    logic sck_s;
    logic mosi_s;
    logic cs_n_s;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync[SYNC_STAGES-1];

    // One-cycle-delayed copies for edge detection.
    logic sck_d;
    logic cs_n_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_d  <= 1'b0;
            cs_n_d <= 1'b1;
        end else begin
            sck_d  <= sck_s;
            cs_n_d <= cs_n_s;
        end
    end

    logic sck_rise_c;
    logic sck_fall_c;
    logic cs_fall_c;
    logic cs_rise_c;

    assign sck_rise_c = sck_s & ~sck_d;
    assign sck_fall_c = ~sck_s & sck_d;
    assign cs_fall_c  = ~cs_n_s & cs_n_d;
    assign cs_rise_c  = cs_n_s & ~cs_n_d;

    // Engine state.
    state_t             state;
    logic [CNT_W-1:0]   bitcnt;
    logic [BYTE_W-1:0]  tx_shift;
    logic [BYTE_W-2:0]  rx_shift;
    logic [BYTE_W-1:0]  tx_hold;

    state_t             state_n;
    logic [CNT_W-1:0]   bitcnt_n;
    logic [BYTE_W-1:0]  tx_shift_n;
    logic [BYTE_W-2:0]  rx_shift_n;
    logic [BYTE_W-1:0]  tx_hold_n;
    logic               txempty_n;
    logic [BYTE_W-1:0]  rxdata_n;
    logic               rxavail_n;
    logic               overrun_n;
    logic               underrun_n;
    logic               oe_n;
    logic               selected_n;
    logic               busy_n;
    logic               load_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            bitcnt      <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            tx_hold     <= '0;
            txempty     <= 1'b1;
            rxdata      <= '0;
            rxavail     <= 1'b0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
            spi_miso_oe <= 1'b0;
            selected    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            bitcnt      <= bitcnt_n;
            tx_shift    <= tx_shift_n;
            rx_shift    <= rx_shift_n;
            tx_hold     <= tx_hold_n;
            txempty     <= txempty_n;
            rxdata      <= rxdata_n;
            rxavail     <= rxavail_n;
            overrun     <= overrun_n;
            underrun    <= underrun_n;
            spi_miso_oe <= oe_n;
            selected    <= selected_n;
            busy        <= busy_n;
        end
    end

    // Next-state and datapath. Register-side strobes are applied first so that
    // engine events (byte completion, flag sets, loads) override them.
    always_comb begin
        state_n    = state;
        bitcnt_n   = bitcnt;
        tx_shift_n = tx_shift;
        rx_shift_n = rx_shift;
        tx_hold_n  = tx_hold;
        txempty_n  = txempty;
        rxdata_n   = rxdata;
        rxavail_n  = rxavail;
        overrun_n  = overrun;
        underrun_n = underrun;
        oe_n       = spi_miso_oe;
        load_c     = 1'b0;

        if (txwrite) begin
            tx_hold_n = txdata;
            txempty_n = 1'b0;
        end
        if (rxread) begin
            rxavail_n = 1'b0;
        end
        if (err_clear) begin
            overrun_n  = 1'b0;
            underrun_n = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (cs_fall_c) begin
                    state_n  = ST_SHIFT;
                    bitcnt_n = '0;
                    oe_n     = 1'b1;
                    load_c   = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_c) begin
                    // Deselect abandons any partial byte in either direction.
                    state_n  = ST_IDLE;
                    bitcnt_n = '0;
                    oe_n     = 1'b0;
                end else if (sck_rise_c && (bitcnt != FULL_CNT)) begin
                    rx_shift_n = {rx_shift[BYTE_W-3:0], mosi_s};
                    bitcnt_n   = bitcnt + CNT_W'(1);
                    if (bitcnt == LAST_BIT) begin
                        rxdata_n  = {rx_shift, mosi_s};
                        rxavail_n = 1'b1;
                        if (rxavail && !rxread) begin
                            overrun_n = 1'b1;
                        end
                    end
                end else if (sck_fall_c) begin
                    if (bitcnt == FULL_CNT) begin
                        bitcnt_n = '0;
                        load_c   = 1'b1;
                    end else begin
                        tx_shift_n = {tx_shift[BYTE_W-2:0], 1'b0};
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Load point: holding register, same-cycle write bypass, or filler byte.
        if (load_c) begin
            if (!txempty) begin
                tx_shift_n = tx_hold;
                txempty_n  = !txwrite;
            end else if (txwrite) begin
                tx_shift_n = txdata;
                txempty_n  = 1'b1;
            end else begin
                tx_shift_n = UNDERRUN_BYTE;
                underrun_n = 1'b1;
            end
        end

        selected_n = ~cs_n_s;
        busy_n     = ~cs_n_s && (bitcnt_n != '0);
    end

    assign spi_miso = tx_shift[BYTE_W-1];

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: directed scenarios followed by randomized
// sessions, compared against a transaction-level model of the holding registers
// and flags.
module tb_spi_target;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HALF        = SYNC_STAGES + 2;
    localparam logic [7:0]  UNDER_BYTE  = 8'hFF;

    logic       clk;
    logic       rst;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_cs_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] txdata;
    logic       txwrite;
    logic       txempty;
    logic [7:0] rxdata;
    logic       rxavail;
    logic       rxread;
    logic       err_clear;
    logic       overrun;
    logic       underrun;
    logic       selected;
    logic       busy;

    spi_target #(
        .SYNC_STAGES  (SYNC_STAGES),
        .UNDERRUN_BYTE(UNDER_BYTE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .txdata     (txdata),
        .txwrite    (txwrite),
        .txempty    (txempty),
        .rxdata     (rxdata),
        .rxavail    (rxavail),
        .rxread     (rxread),
        .err_clear  (err_clear),
        .overrun    (overrun),
        .underrun   (underrun),
        .selected   (selected),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: holding-register contents and flag state.
    logic       m_hold_full;
    logic [7:0] m_hold;
    logic       m_rxavail;
    logic [7:0] m_rxdata;
    logic       m_overrun;
    logic       m_underrun;

    // Session description.
    int         s_n;
    logic [7:0] s_tx[4];
    bit         s_wr[4];       // [0]: preload before CS; [k]: written during byte k-1
    logic [7:0] s_rx[4];
    bit         s_rd[4];       // read byte k during byte k+1 (last byte: after deselect)
    bit         s_rd_done[4];  // read exactly on byte k's completion cycle
    bit         s_wr_cs;
    logic [7:0] s_wr_cs_val;

    // Snapshot of status taken at the end of the 8th SCK high phase.
    logic [7:0] snap_rxdata;
    logic       snap_rxavail;
    logic       snap_overrun;
    logic       snap_underrun;
    logic       snap_txempty;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        m_hold_full = 1'b0;
        m_hold      = 8'h00;
        m_rxavail   = 1'b0;
        m_rxdata    = 8'h00;
        m_overrun   = 1'b0;
        m_underrun  = 1'b0;
    endfunction

    // Byte the target shifts out at a load point, given an optional same-cycle write.
    function automatic logic [7:0] m_load(input bit wr, input logic [7:0] val);
        logic [7:0] r;
        if (m_hold_full) begin
            r = m_hold;
            if (wr) m_hold = val;
            else m_hold_full = 1'b0;
        end else if (wr) begin
            r = val;
        end else begin
            r = UNDER_BYTE;
            m_underrun = 1'b1;
        end
        return r;
    endfunction

    function automatic void m_complete(input logic [7:0] b, input bit rd_same);
        if (m_rxavail && !rd_same) m_overrun = 1'b1;
        m_rxavail = 1'b1;
        m_rxdata  = b;
    endfunction

    task automatic tx_write(input logic [7:0] v);
        txdata  = v;
        txwrite = 1'b1;
        wait_clks(1);
        txwrite = 1'b0;
        m_hold_full = 1'b1;
        m_hold      = v;
    endtask

    task automatic rx_read();
        rxread = 1'b1;
        wait_clks(1);
        rxread = 1'b0;
        m_rxavail = 1'b0;
    endtask

    task automatic clear_errs();
        err_clear = 1'b1;
        wait_clks(1);
        err_clear = 1'b0;
        m_overrun  = 1'b0;
        m_underrun = 1'b0;
        check("clr_overrun", {7'd0, overrun}, {7'd0, m_overrun});
        check("clr_underrun", {7'd0, underrun}, {7'd0, m_underrun});
    endtask

    // Host side, mode 0: MOSI set while SCK low, MISO sampled just before SCK rises.
    task automatic spi_xfer(input logic [7:0] mo, input int nbits, input bit rd_done,
                            output logic [7:0] mi);
        logic [7:0] bits;
        bits = mo;
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = bits[7-i];
            wait_clks(HALF);
            mi = {mi[6:0], spi_miso};
            spi_sck = 1'b1;
            if (rd_done && i == 7) begin
                wait_clks(SYNC_STAGES);
                rxread = 1'b1;
                wait_clks(1);
                rxread = 1'b0;
                wait_clks(HALF - SYNC_STAGES - 1);
            end else begin
                wait_clks(HALF);
            end
            if (i == 7) begin
                snap_rxdata   = rxdata;
                snap_rxavail  = rxavail;
                snap_overrun  = overrun;
                snap_underrun = underrun;
                snap_txempty  = txempty;
            end
            spi_sck = 1'b0;
        end
    endtask

    task automatic check_final(input string tag);
        check({tag, "_oe"}, {7'd0, spi_miso_oe}, 8'd0);
        check({tag, "_selected"}, {7'd0, selected}, 8'd0);
        check({tag, "_busy"}, {7'd0, busy}, 8'd0);
        check({tag, "_rxdata"}, rxdata, m_rxdata);
        check({tag, "_rxavail"}, {7'd0, rxavail}, {7'd0, m_rxavail});
        check({tag, "_overrun"}, {7'd0, overrun}, {7'd0, m_overrun});
        check({tag, "_underrun"}, {7'd0, underrun}, {7'd0, m_underrun});
        check({tag, "_txempty"}, {7'd0, txempty}, {7'd0, !m_hold_full});
    endtask

    task automatic run_session(input string tag);
        logic [7:0] got;
        logic [7:0] exp_mi;
        if (s_wr[0]) tx_write(s_tx[0]);
        spi_cs_n = 1'b0;
        if (s_wr_cs) begin
            wait_clks(SYNC_STAGES);
            txdata  = s_wr_cs_val;
            txwrite = 1'b1;
            wait_clks(1);
            txwrite = 1'b0;
        end
        exp_mi = m_load(s_wr_cs, s_wr_cs_val);
        for (int k = 0; k < s_n; k++) begin
            fork
                spi_xfer(s_rx[k], 8, s_rd_done[k], got);
                begin
                    wait_clks(20);
                    if (k + 1 < s_n && s_wr[k+1]) tx_write(s_tx[k+1]);
                    if (k > 0 && s_rd[k-1]) rx_read();
                end
            join
            check({tag, "_miso"}, got, exp_mi);
            m_complete(s_rx[k], s_rd_done[k]);
            check({tag, "_snap_rxdata"}, snap_rxdata, m_rxdata);
            check({tag, "_snap_rxavail"}, {7'd0, snap_rxavail}, {7'd0, m_rxavail});
            check({tag, "_snap_overrun"}, {7'd0, snap_overrun}, {7'd0, m_overrun});
            check({tag, "_snap_underrun"}, {7'd0, snap_underrun}, {7'd0, m_underrun});
            check({tag, "_snap_txempty"}, {7'd0, snap_txempty}, {7'd0, !m_hold_full});
            exp_mi = m_load(1'b0, 8'h00);  // reload on the 8th SCK falling edge
        end
        wait_clks(HALF);
        spi_cs_n = 1'b1;
        wait_clks(6);
        check_final(tag);
        if (s_rd[s_n-1]) begin
            rx_read();
            check({tag, "_rd_clear"}, {7'd0, rxavail}, 8'd0);
        end
    endtask

    task automatic clear_session();
        s_n = 1;
        s_wr_cs = 1'b0;
        s_wr_cs_val = 8'h00;
        for (int k = 0; k < 4; k++) begin
            s_tx[k] = 8'h00;
            s_wr[k] = 1'b0;
            s_rx[k] = 8'h00;
            s_rd[k] = 1'b0;
            s_rd_done[k] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] got;
        rst = 1'b1;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        txdata = 8'h00;
        txwrite = 1'b0;
        rxread = 1'b0;
        err_clear = 1'b0;
        m_reset();
        clear_session();
        wait_clks(3);
        check("rst_miso", {7'd0, spi_miso}, 8'd0);
        check("rst_txempty", {7'd0, txempty}, 8'd1);
        check_final("rst");
        rst = 1'b0;
        wait_clks(5);
        check_final("post_rst");

        // Single byte.
        clear_session();
        s_wr[0] = 1'b1; s_tx[0] = 8'hA5; s_rx[0] = 8'h3C; s_rd[0] = 1'b1;
        run_session("single");
        clear_errs();

        // Back-to-back under one CS.
        clear_session();
        s_n = 2;
        s_wr[0] = 1'b1; s_tx[0] = 8'h11; s_wr[1] = 1'b1; s_tx[1] = 8'h22;
        s_rx[0] = 8'h01; s_rx[1] = 8'h02; s_rd[0] = 1'b1; s_rd[1] = 1'b1;
        run_session("b2b");
        clear_errs();

        // Underrun and overrun.
        clear_session();
        s_n = 2;
        s_rx[0] = 8'h6D; s_rx[1] = 8'hC3;
        run_session("uo");
        check("uo_rxdata2", rxdata, 8'hC3);
        clear_errs();
        rx_read();

        // CS abort after five bits.
        spi_cs_n = 1'b0;
        got = m_load(1'b0, 8'h00);
        spi_xfer(8'h9B, 5, 1'b0, got);
        check("abort_busy_mid", {7'd0, busy}, 8'd1);
        check("abort_sel_mid", {7'd0, selected}, 8'd1);
        wait_clks(HALF);
        spi_cs_n = 1'b1;
        wait_clks(6);
        check_final("abort");
        clear_errs();
        clear_session();
        s_wr[0] = 1'b1; s_tx[0] = 8'h7E; s_rx[0] = 8'h4B; s_rd[0] = 1'b1;
        run_session("after_abort");
        clear_errs();

        // Read on the completion cycle of a byte that lands on unread data.
        clear_session();
        s_n = 2;
        s_wr[0] = 1'b1; s_tx[0] = 8'h33; s_wr[1] = 1'b1; s_tx[1] = 8'h44;
        s_rx[0] = 8'hE1; s_rx[1] = 8'h1E; s_rd_done[1] = 1'b1; s_rd[1] = 1'b1;
        run_session("rd_same");
        clear_errs();

        // Write on the CS-assert load cycle with the holding register empty.
        clear_session();
        s_wr_cs = 1'b1; s_wr_cs_val = 8'h5A; s_rx[0] = 8'h87; s_rd[0] = 1'b1;
        run_session("wr_same");
        clear_errs();

        // Reset in the middle of a transfer.
        tx_write(8'hC9);
        spi_cs_n = 1'b0;
        spi_xfer(8'hF0, 3, 1'b0, got);
        rst = 1'b1;
        #2;
        m_reset();
        check("midrst_miso", {7'd0, spi_miso}, 8'd0);
        check_final("midrst");
        spi_cs_n = 1'b1;
        spi_sck = 1'b0;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(6);
        clear_session();
        s_wr[0] = 1'b1; s_tx[0] = 8'h96; s_rx[0] = 8'h2D; s_rd[0] = 1'b1;
        run_session("after_rst");
        clear_errs();

        // Randomized sessions.
        for (int r = 0; r < 12; r++) begin
            clear_session();
            s_n = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) begin
                s_tx[k] = 8'($urandom);
                s_rx[k] = 8'($urandom);
                s_wr[k] = bit'($urandom_range(0, 3) != 0);
                s_rd[k] = bit'($urandom_range(0, 1));
                s_rd_done[k] = bit'($urandom_range(0, 3) == 0);
            end
            if (!m_hold_full && !s_wr[0] && $urandom_range(0, 1) == 1) begin
                s_wr_cs = 1'b1;
                s_wr_cs_val = 8'($urandom);
            end
            run_session("rand");
            if ($urandom_range(0, 1) == 1) clear_errs();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
